modn_counter: RTL and testbench

Parametrised modulo-N counter with up/down direction, synchronous clear and preset load, a combinational terminal-count output for synchronous cascading, and a registered wrap pulse. It is the generic digit stage of the clock datapath: seconds and minutes units use MODULUS=10, tens use MODULUS=6, and hours use MODULUS=24 or 12. Stages chain by driving each stage's `ena` from the previous stage's `tc`.

---
 rtl/modn_counter.sv | 144 ++++++++++++++
 tb/tb_modn_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/modn_counter.sv
// ---------------------------------------------------------------------------
// modn_counter
//
// Generic modulo-N digit stage for the clock datapath. Counts in the range
// 0 .. MODULUS-1, up or down, with synchronous clear and preset load. Stages
// cascade synchronously by feeding one stage's tc_o into the next stage's
// ena_i.
//
// Build option:
//   MODN_COUNTER_DOWN_EN  defined   -> dir_i selects up (0) or down (1)
//                         undefined -> dir_i is ignored, count up only
//   The port list is the same in both builds.
//
// Parameters:
//   WIDTH    counter width in bits
//   MODULUS  count range 0 .. MODULUS-1, legal for 2 <= MODULUS <= 2**WIDTH
//
// Ports:
//   clk_i    clock, rising edge
//   res_i    synchronous active-high reset
//   ena_i    count enable, one step per cycle
//   dir_i    0 = up, 1 = down
//   clr_i    synchronous clear to 0
//   load_i   synchronous preset from din_i
//   din_i    preset value
//   cnt_o    current count (registered)
//   tc_o     terminal count, combinational: the next enabled step wraps
//   carry_o  one-cycle pulse in the cycle after a wrap
//   err_o    one-cycle pulse in the cycle after an out-of-range load
// ---------------------------------------------------------------------------
module modn_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk_i,
  input  logic             res_i,
  input  logic             ena_i,
  input  logic             dir_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o,
  output logic             carry_o,
  output logic             err_o
);

  // Reject parameter combinations whose range cannot be represented.
  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_param
    $error("modn_counter: MODULUS=%0d is illegal for WIDTH=%0d", MODULUS, WIDTH);
  end

  // Compares run one bit wider than the counter so that MODULUS = 2**WIDTH
  // is representable.
  localparam int             MAXV    = MODULUS - 1;
  localparam logic [WIDTH:0] MOD_EXT = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0] MAX_EXT = MAXV[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_CNT = MAXV[WIDTH-1:0];

`ifdef MODN_COUNTER_DOWN_EN
  localparam logic DOWN_EN = 1'b1;
`else
  localparam logic DOWN_EN = 1'b0;
`endif

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;

  logic             dirEff;
  logic [WIDTH:0]   cntExt;
  logic             atMax;
  logic             atZero;
  logic             outOfRange;
  logic             dinValid;

  // In the up-only build the direction input is masked to "up".
  assign dirEff     = dir_i & DOWN_EN;
  assign cntExt     = {1'b0, cnt_q};
  assign atMax      = (cntExt == MAX_EXT);
  assign atZero     = (cnt_q == '0);
  assign outOfRange = (cntExt >= MOD_EXT);
  assign dinValid   = ({1'b0, din_i} < MOD_EXT);

  // Terminal count depends only on ena/dir and the count register, so a
  // chain of stages ripples enables within one cycle. It is deliberately not
  // masked by clr/load because downstream stages see the same controls.
  assign tc_o = ena_i & ((~dirEff & atMax) | (dirEff & atZero));

  // Next-state logic, priority clr > load > ena (reset is handled in the
  // register). Pulses default low so they last exactly one cycle.
  always_comb begin
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    err_d   = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      if (dinValid) begin
        cnt_d = din_i;
      end else begin
        err_d = 1'b1;
      end
    end else if (ena_i) begin
      if (outOfRange) begin
        // Recover from an upset state without signalling a wrap.
        cnt_d = '0;
      end else if (dirEff) begin
        if (atZero) begin
          cnt_d   = MAX_CNT;
          carry_d = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end else begin
        if (atMax) begin
          cnt_d   = '0;
          carry_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
    end
  end

  // State register with synchronous reset; reset also drops any pending
  // carry/err pulse.
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign carry_o = carry_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_modn_counter.sv
// ---------------------------------------------------------------------------
// tb_modn_counter
//
// Self-checking bench for modn_counter. Exercises a WIDTH=4/MODULUS=10 stage
// from a vector table, a 10x6 cascade, and the WIDTH=3/MODULUS=8 and
// WIDTH=2/MODULUS=2 edge configurations. Expectations follow the build
// option MODN_COUNTER_DOWN_EN.
// ---------------------------------------------------------------------------
module tb_modn_counter;

`ifdef MODN_COUNTER_DOWN_EN
   localparam bit DOWN = 1'b1;
`else
   localparam bit DOWN = 1'b0;
`endif

   logic clock = 1'b0;

   // Main stage (WIDTH=4, MODULUS=10)
   logic       resA = 1'b1, enaA = 1'b0, dirA = 1'b0, clrA = 1'b0, loadA = 1'b0;
   logic [3:0] dinA = '0;
   logic [3:0] cntA;
   logic       tcA, carryA, errA;

   // Cascade pair (MODULUS=10 feeding MODULUS=6)
   logic       resC = 1'b1, enaC = 1'b0;
   logic [3:0] loCnt, hiCnt;
   logic       loTc, hiTc, loCarry, hiCarry, loErr, hiErr;

   // Edge configurations
   logic       resE = 1'b1, enaE = 1'b0, dirE = 1'b0;
   logic [2:0] e1Cnt;
   logic [1:0] e2Cnt;
   logic       e1Tc, e1Carry, e1Err, e2Tc, e2Carry, e2Err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       res, clr, load, ena, dir;
      logic [3:0] din;
      logic       expTc;
      logic [3:0] expCnt;
      logic       expCarry, expErr;
   } vec_t;

   vec_t vecs[$];

   always #5 clock = ~clock;

   modn_counter #(.WIDTH(4), .MODULUS(10)) dutA (
      .clk_i(clock), .res_i(resA), .ena_i(enaA), .dir_i(dirA),
      .clr_i(clrA), .load_i(loadA), .din_i(dinA),
      .cnt_o(cntA), .tc_o(tcA), .carry_o(carryA), .err_o(errA));

   modn_counter #(.WIDTH(4), .MODULUS(10)) dutLo (
      .clk_i(clock), .res_i(resC), .ena_i(enaC), .dir_i(1'b0),
      .clr_i(1'b0), .load_i(1'b0), .din_i(4'd0),
      .cnt_o(loCnt), .tc_o(loTc), .carry_o(loCarry), .err_o(loErr));

   modn_counter #(.WIDTH(4), .MODULUS(6)) dutHi (
      .clk_i(clock), .res_i(resC), .ena_i(loTc), .dir_i(1'b0),
      .clr_i(1'b0), .load_i(1'b0), .din_i(4'd0),
      .cnt_o(hiCnt), .tc_o(hiTc), .carry_o(hiCarry), .err_o(hiErr));

   modn_counter #(.WIDTH(3), .MODULUS(8)) dutE1 (
      .clk_i(clock), .res_i(resE), .ena_i(enaE), .dir_i(dirE),
      .clr_i(1'b0), .load_i(1'b0), .din_i(3'd0),
      .cnt_o(e1Cnt), .tc_o(e1Tc), .carry_o(e1Carry), .err_o(e1Err));

   modn_counter #(.WIDTH(2), .MODULUS(2)) dutE2 (
      .clk_i(clock), .res_i(resE), .ena_i(enaE), .dir_i(dirE),
      .clr_i(1'b0), .load_i(1'b0), .din_i(2'd0),
      .cnt_o(e2Cnt), .tc_o(e2Tc), .carry_o(e2Carry), .err_o(e2Err));

   function automatic vec_t mk(input logic res, clr, load, ena, dir,
                               input logic [3:0] din, input logic expTc,
                               input logic [3:0] expCnt,
                               input logic expCarry, expErr);
      vec_t v;
      v.res = res; v.clr = clr; v.load = load; v.ena = ena; v.dir = dir;
      v.din = din; v.expTc = expTc; v.expCnt = expCnt;
      v.expCarry = expCarry; v.expErr = expErr;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      resA  = v.res;
      clrA  = v.clr;
      loadA = v.load;
      enaA  = v.ena;
      dirA  = v.dir;
      dinA  = v.din;
   endtask

   initial begin
      int m1, m2, total;
      bit dEff, w1, w2;

      // Build the vector table for the main stage.
      for (int i = 0; i < 12; i++)
         vecs.push_back(mk(0,0,0,1,0,4'd0, (i == 9), 4'((i + 1) % 10), (i == 9), 0));
      vecs.push_back(mk(0,0,1,0,0,4'd1,  0, 4'd1, 0, 0));
      if (DOWN) begin
         vecs.push_back(mk(0,0,0,1,1,4'd0, 0, 4'd0, 0, 0));
         vecs.push_back(mk(0,0,0,1,1,4'd0, 1, 4'd9, 1, 0));
         vecs.push_back(mk(0,0,0,1,1,4'd0, 0, 4'd8, 0, 0));
      end else begin
         vecs.push_back(mk(0,0,0,1,1,4'd0, 0, 4'd2, 0, 0));
         vecs.push_back(mk(0,0,0,1,1,4'd0, 0, 4'd3, 0, 0));
         vecs.push_back(mk(0,0,0,1,1,4'd0, 0, 4'd4, 0, 0));
      end
      vecs.push_back(mk(0,0,1,0,0,4'd7,  0, 4'd7, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,4'd12, 0, 4'd7, 0, 1));
      vecs.push_back(mk(0,0,0,0,0,4'd0,  0, 4'd7, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,4'd9,  0, 4'd9, 0, 0));
      vecs.push_back(mk(0,0,1,1,0,4'd3,  1, 4'd3, 0, 0));
      vecs.push_back(mk(1,1,1,0,0,4'd5,  0, 4'd0, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,4'd4,  0, 4'd4, 0, 0));
      vecs.push_back(mk(0,1,1,0,0,4'd5,  0, 4'd0, 0, 0));
      vecs.push_back(mk(0,1,0,1,0,4'd0,  0, 4'd0, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,4'd10, 0, 4'd0, 0, 1));
      vecs.push_back(mk(1,0,1,0,0,4'd15, 0, 4'd0, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,4'd9,  0, 4'd9, 0, 0));
      vecs.push_back(mk(1,0,0,1,0,4'd0,  1, 4'd0, 0, 0));
      vecs.push_back(mk(0,0,0,0,0,4'd0,  0, 4'd0, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,4'd9,  0, 4'd9, 0, 0));
      if (DOWN) begin
         vecs.push_back(mk(0,0,0,1,1,4'd0, 0, 4'd8, 0, 0));
         vecs.push_back(mk(0,0,0,0,0,4'd0, 0, 4'd8, 0, 0));
      end else begin
         vecs.push_back(mk(0,0,0,1,1,4'd0, 1, 4'd0, 1, 0));
         vecs.push_back(mk(0,0,0,0,0,4'd0, 0, 4'd0, 0, 0));
      end

      // Reset for two cycles.
      tick();
      tick();
      checkOutput("reset cnt", cntA, 0);
      checkOutput("reset carry", carryA, 0);
      checkOutput("reset err", errA, 0);
      checkOutput("reset tc idle", tcA, 0);
      resA = 1'b0;
      enaA = 1'b1;
      dirA = 1'b1;
      #1;
      checkOutput("reset tc down", tcA, DOWN);
      enaA = 1'b0;
      dirA = 1'b0;

      // Table-driven sequence.
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("vec%0d tc", i), tcA, vecs[i].expTc);
         tick();
         checkOutput($sformatf("vec%0d cnt", i), cntA, vecs[i].expCnt);
         checkOutput($sformatf("vec%0d carry", i), carryA, vecs[i].expCarry);
         checkOutput($sformatf("vec%0d err", i), errA, vecs[i].expErr);
      end
      applyStimulus(mk(0,0,0,0,0,4'd0,0,4'd0,0,0));

      // Cascade: 60 enabled cycles take the pair 00 -> 59 -> 00.
      tick();
      resC = 1'b0;
      enaC = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         #1;
         checkOutput($sformatf("cascade hiTc k%0d", k), hiTc, (k == 60));
         tick();
         total = int'(hiCnt) * 10 + int'(loCnt);
         checkOutput($sformatf("cascade value k%0d", k), total, k % 60);
         checkOutput($sformatf("cascade hiCarry k%0d", k), hiCarry, (k == 60));
         checkOutput($sformatf("cascade loCarry k%0d", k), loCarry, (k % 10 == 0));
      end
      enaC = 1'b0;
      checkOutput("cascade errs", {loErr, hiErr}, 0);

      // Edge configurations: up sweep then down sweep.
      tick();
      resE = 1'b0;
      m1 = 0;
      m2 = 0;
      for (int d = 0; d < 2; d++) begin
         for (int s = 0; s < 16; s++) begin
            dirE = d[0];
            enaE = 1'b1;
            dEff = d[0] & DOWN;
            #1;
            checkOutput($sformatf("E1 tc d%0d s%0d", d, s), e1Tc, dEff ? (m1 == 0) : (m1 == 7));
            checkOutput($sformatf("E2 tc d%0d s%0d", d, s), e2Tc, dEff ? (m2 == 0) : (m2 == 1));
            w1 = dEff ? (m1 == 0) : (m1 == 7);
            w2 = dEff ? (m2 == 0) : (m2 == 1);
            m1 = dEff ? (m1 + 7) % 8 : (m1 + 1) % 8;
            m2 = (m2 + 1) % 2;
            tick();
            checkOutput($sformatf("E1 cnt d%0d s%0d", d, s), e1Cnt, m1);
            checkOutput($sformatf("E1 carry d%0d s%0d", d, s), e1Carry, w1);
            checkOutput($sformatf("E2 cnt d%0d s%0d", d, s), e2Cnt, m2);
            checkOutput($sformatf("E2 carry d%0d s%0d", d, s), e2Carry, w2);
            checkOutput($sformatf("E2 range d%0d s%0d", d, s), (e2Cnt < 2'd2), 1);
         end
      end
      enaE = 1'b0;
      checkOutput("edge errs", {e1Err, e2Err}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
